// File: rtl/smp_pkg.sv
// Shared definitions for the two-CPU snooping bus arbiter: FSM states,
// miss-type encoding and the default block-address width.
package smp_pkg;

  localparam int unsigned ADDR_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SNOOP,
    WBACK,
    MEM,
    DONE
  } arb_state_e;

  typedef enum logic {
    READ_MISS  = 1'b0,
    WRITE_MISS = 1'b1
  } miss_op_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin selector: on a tie the CPU not served last wins,
// a lone request wins outright. Purely combinational.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter for two private caches: grants one miss at a time,
// snoops the other cache, writes back a dirty copy and fetches from memory.
module bus_arbiter
  import smp_pkg::*;
#(
  parameter int unsigned ADDR_W = smp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              op_0,
  input  logic              op_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  output logic              grant_0,
  output logic              grant_1,
  output logic [ADDR_W-1:0] addr_out,
  output logic              search_0,
  output logic              search_1,
  input  logic              search_found_0,
  input  logic              search_found_1,
  input  logic              dirty_0,
  input  logic              dirty_1,
  output logic              wback_0,
  output logic              wback_1,
  output logic              inv_0,
  output logic              inv_1,
  output logic              mm_re,
  output logic              mm_we,
  input  logic              mm_rdy,
  output logic              done_0,
  output logic              done_1
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  miss_op_e          op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              found_q, found_d;
  logic              dirty_q, dirty_d;
  logic              last_q, last_d;

  logic winner;
  logic busy, srch, wb, inv, done;
  logic snoop_found, snoop_dirty;

  rr_arbiter_2 u_rr (
    .req    ({req_1, req_0}),
    .last   (last_q),
    .winner (winner)
  );

  // The snooped cache is always the one that does not own the bus.
  assign snoop_found = owner_q ? search_found_0 : search_found_1;
  assign snoop_dirty = owner_q ? dirty_0 : dirty_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= READ_MISS;
      addr_q  <= '0;
      found_q <= 1'b0;
      dirty_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      found_q <= found_d;
      dirty_q <= dirty_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    addr_d  = addr_q;
    found_d = found_q;
    dirty_d = dirty_q;
    last_d  = last_q;
    busy    = 1'b1;
    srch    = 1'b0;
    wb      = 1'b0;
    inv     = 1'b0;
    done    = 1'b0;
    mm_re   = 1'b0;
    mm_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req_0 || req_1) begin
          owner_d = winner;
          op_d    = winner ? miss_op_e'(op_1) : miss_op_e'(op_0);
          addr_d  = winner ? addr_1 : addr_0;
          state_d = GRANT;
        end
      end
      GRANT: state_d = SNOOP;
      SNOOP: begin
        srch    = 1'b1;
        found_d = snoop_found;
        dirty_d = snoop_dirty;
        state_d = (snoop_found && snoop_dirty) ? WBACK : MEM;
      end
      WBACK: begin
        // Only reachable with a found dirty copy; the qualifier makes that explicit.
        wb    = found_q & dirty_q;
        mm_we = found_q & dirty_q;
        if (mm_rdy) state_d = MEM;
      end
      MEM: begin
        mm_re = 1'b1;
        if (mm_rdy) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        inv     = (op_q == WRITE_MISS) && found_q;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    grant_0  = busy & ~owner_q;
    grant_1  = busy & owner_q;
    addr_out = busy ? addr_q : '0;
    search_0 = srch & owner_q;
    search_1 = srch & ~owner_q;
    wback_0  = wb & owner_q;
    wback_1  = wb & ~owner_q;
    inv_0    = inv & owner_q;
    inv_1    = inv & ~owner_q;
    done_0   = done & ~owner_q;
    done_1   = done & owner_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a driver pushes expected transactions from a
// round-robin/latency model, a negedge monitor pops and checks them on done.
module tb_bus_arbiter;
  import smp_pkg::*;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_0, req_1, op_0, op_1;
  logic [AW-1:0] addr_0, addr_1, addr_out;
  logic          grant_0, grant_1, search_0, search_1;
  logic          search_found_0, search_found_1, dirty_0, dirty_1;
  logic          wback_0, wback_1, inv_0, inv_1;
  logic          mm_re, mm_we, mm_rdy, done_0, done_1;

  bus_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
    .addr_0(addr_0), .addr_1(addr_1),
    .grant_0(grant_0), .grant_1(grant_1), .addr_out(addr_out),
    .search_0(search_0), .search_1(search_1),
    .search_found_0(search_found_0), .search_found_1(search_found_1),
    .dirty_0(dirty_0), .dirty_1(dirty_1),
    .wback_0(wback_0), .wback_1(wback_1), .inv_0(inv_0), .inv_1(inv_1),
    .mm_re(mm_re), .mm_we(mm_we), .mm_rdy(mm_rdy),
    .done_0(done_0), .done_1(done_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          owner;
    logic [AW-1:0] addr;
    logic          inv;
    logic          wb;
    int            lat;
    int            done_cyc;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_served = 1;
  int   lat_cfg[2] = '{1, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [22:0] outs();
    return {grant_1, grant_0, addr_out, search_1, search_0, wback_1, wback_0,
            inv_1, inv_0, mm_re, mm_we, done_1, done_0};
  endfunction

  function automatic txn_t mk_txn(input logic owner, input logic op, input logic [AW-1:0] a,
                                  input logic f, input logic d, input int lat);
    txn_t t;
    t.owner = owner;
    t.addr = a;
    t.inv = op && f;
    t.wb = f && d;
    t.lat = lat;
    t.done_cyc = 0;
    return t;
  endfunction

  // Cycles from the IDLE sampling cycle to the done pulse.
  function automatic int dur(input txn_t t);
    return 3 + (t.wb ? t.lat : 0) + t.lat;
  endfunction

  // Memory responder: raises mm_rdy in the lat-th cycle of each strobe run; noise otherwise.
  initial begin
    int cnt = 0;
    int kind, pkind = 0;
    mm_rdy = 1'b0;
    forever begin
      @(negedge clk);
      kind = mm_we ? 2 : (mm_re ? 1 : 0);
      if (!rst_n || kind == 0) begin
        cnt = 0;
        mm_rdy = rst_n ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        if (kind != pkind) cnt = 0;
        else cnt++;
        mm_rdy = (cnt >= lat_cfg[grant_1 ? 1 : 0] - 1);
      end
      pkind = kind;
    end
  end

  // Monitor
  initial begin
    txn_t cur;
    bit   active = 0;
    int   start = 0, off, n_grant, n_bad, n_srch, srch_off, n_wb, n_we, n_re, re_off;
    logic ow, g_own, g_oth, s_own, s_oth, wb_own, wb_oth, i_own, i_oth, d_own, d_oth;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
        continue;
      end
      chk("exclusive", {61'd0, grant_0 & grant_1, search_0 & search_1, mm_re & mm_we}, '0);
      if (!active && (grant_0 || grant_1) && sb.size() > 0) begin
        cur = sb[0];
        active = 1;
        start = cyc;
        n_grant = 0; n_bad = 0; n_srch = 0; srch_off = -1;
        n_wb = 0; n_we = 0; n_re = 0; re_off = -1;
        chk("grant_owner", {63'd0, grant_1}, {63'd0, cur.owner});
      end
      if (active) begin
        off = cyc - start;
        ow = cur.owner;
        g_own = ow ? grant_1 : grant_0;   g_oth = ow ? grant_0 : grant_1;
        s_own = ow ? search_1 : search_0; s_oth = ow ? search_0 : search_1;
        wb_own = ow ? wback_1 : wback_0;  wb_oth = ow ? wback_0 : wback_1;
        i_own = ow ? inv_1 : inv_0;       i_oth = ow ? inv_0 : inv_1;
        d_own = ow ? done_1 : done_0;     d_oth = ow ? done_0 : done_1;
        if (g_own) n_grant++;
        if (g_oth || s_own || wb_own || i_own || d_oth || addr_out !== cur.addr) n_bad++;
        if (i_oth && !d_own) n_bad++;
        if (s_oth) begin n_srch++; srch_off = off; end
        if (wb_oth) n_wb++;
        if (mm_we) n_we++;
        if (mm_re) begin
          if (n_re == 0) re_off = off;
          n_re++;
        end
        if (d_own) begin
          chk("done_cycle", 64'(cyc), 64'(cur.done_cyc));
          chk("grant_cycles", 64'(n_grant), 64'(dur(cur)));
          chk("protocol_violations", 64'(n_bad), 0);
          chk("search_count", 64'(n_srch), 1);
          chk("search_offset", 64'(srch_off), 1);
          chk("wback_cycles", 64'(n_wb), 64'(cur.wb ? cur.lat : 0));
          chk("mm_we_cycles", 64'(n_we), 64'(cur.wb ? cur.lat : 0));
          chk("mm_re_cycles", 64'(n_re), 64'(cur.lat));
          chk("mm_re_offset", 64'(re_off), 64'(2 + (cur.wb ? cur.lat : 0)));
          chk("inv_at_done", {63'd0, i_oth}, {63'd0, cur.inv});
          chk("addr_out", 64'(addr_out), 64'(cur.addr));
          void'(sb.pop_front());
          active = 0;
        end else if (!g_own) begin
          errors++; checks++;
          $display("FAIL grant_dropped: owner grant low without done at cycle %0d", cyc);
          void'(sb.pop_front());
          active = 0;
        end
      end else begin
        chk("idle_outputs", 64'(outs()), 0);
      end
    end
  end

  task automatic drive_idle();
    req_0 = 0; req_1 = 0; op_0 = 0; op_1 = 0; addr_0 = '0; addr_1 = '0;
    search_found_0 = 0; search_found_1 = 0; dirty_0 = 0; dirty_1 = 0;
  endtask

  // f0/d0: snoop result seen during cpu0's transaction (driven by cache 1); f1/d1 likewise.
  task automatic run_scn(input logic r0, input logic r1, input logic o0, input logic o1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic f0, input logic d0, input logic f1, input logic d1,
                         input int l0, input int l1);
    txn_t t[2];
    int   first, pending, dc;
    @(negedge clk);
    t[0] = mk_txn(1'b0, o0, a0, f0, d0, l0);
    t[1] = mk_txn(1'b1, o1, a1, f1, d1, l1);
    first = (r0 && r1) ? (last_served == 0 ? 1 : 0) : (r0 ? 0 : 1);
    dc = cyc + dur(t[first]);
    t[first].done_cyc = dc;
    sb.push_back(t[first]);
    last_served = first;
    if (r0 && r1) begin
      t[1-first].done_cyc = dc + 1 + dur(t[1-first]);
      sb.push_back(t[1-first]);
      last_served = 1 - first;
    end
    req_0 = r0; op_0 = o0; addr_0 = a0;
    req_1 = r1; op_1 = o1; addr_1 = a1;
    search_found_1 = f0; dirty_1 = d0;
    search_found_0 = f1; dirty_0 = d1;
    lat_cfg[0] = l0; lat_cfg[1] = l1;
    pending = int'(r0) + int'(r1);
    for (int k = 0; k < 300 && pending > 0; k++) begin
      @(negedge clk);
      if (grant_0 && req_0) begin op_0 = 1'($urandom); addr_0 = AW'($urandom); end
      if (grant_1 && req_1) begin op_1 = 1'($urandom); addr_1 = AW'($urandom); end
      if (done_0 && req_0) begin req_0 = 0; pending--; end
      if (done_1 && req_1) begin req_1 = 0; pending--; end
    end
    if (pending > 0) begin
      errors++; checks++;
      $display("FAIL scenario_timeout: %0d requests still pending at cycle %0d", pending, cyc);
      req_0 = 0; req_1 = 0;
      sb.delete();
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    #1 chk("reset_outputs", 64'(outs()), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two back-to-back ties from reset: cpu0, cpu1, cpu0, cpu1.
    run_scn(1, 1, 0, 1, 11'h011, 11'h022, 0, 0, 0, 0, 1, 1);
    run_scn(1, 1, 1, 0, 11'h033, 11'h044, 0, 0, 0, 0, 2, 1);
    // Minimum-latency read miss from cpu0.
    run_scn(1, 0, 0, 0, 11'h155, 11'h000, 0, 0, 0, 0, 1, 1);
    // cpu1 write miss hitting a dirty copy in cache 0, memory ready after 3 cycles.
    run_scn(0, 1, 0, 1, 11'h000, 11'h0A0, 0, 0, 1, 1, 3, 3);
    // Clean shared copy on a read miss: no write-back, no invalidate.
    run_scn(1, 0, 0, 0, 11'h2B4, 11'h000, 1, 0, 0, 0, 2, 2);

    // cpu0 served last; cpu1 transaction aborted in MEM; next tie must still go to cpu0.
    run_scn(1, 0, 0, 0, 11'h321, 11'h000, 0, 0, 0, 0, 1, 1);
    begin
      txn_t t;
      bit   seen = 0;
      @(negedge clk);
      t = mk_txn(1'b1, 1'b1, 11'h456, 1'b0, 1'b0, 8);
      t.done_cyc = cyc + dur(t);
      sb.push_back(t);
      req_1 = 1; op_1 = 1; addr_1 = 11'h456;
      search_found_0 = 0; dirty_0 = 0;
      lat_cfg[1] = 8;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        if (mm_re) seen = 1;
      end
      if (!seen) begin
        errors++; checks++;
        $display("FAIL reset_wait: mm_re never seen (cycle %0d)", cyc);
      end
      #2 rst_n = 1'b0;
      sb.delete();
      last_served = 1;
      #1 chk("reset_mid_mem_outputs", 64'(outs()), 0);
      drive_idle();
      repeat (3) @(negedge clk);
      chk("reset_held_outputs", 64'(outs()), 0);
      rst_n = 1'b1;
    end
    run_scn(1, 1, 0, 0, 11'h0F0, 11'h0F1, 0, 0, 0, 0, 1, 1);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(1, 3);
      run_scn(r[0], r[1], 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(1, 4), $urandom_range(1, 4));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
